dffmem_array: RTL and testbench
===============================

DFFMEM_ARRAY -- requirements
Module: dffmem_array

Interface
REQ-001 Parameter DATA_W, default 16, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 8, number of words, 2..256.
REQ-003 Parameter ADDR_W, default 12, address width; SHALL satisfy 2^ADDR_W >= DEPTH.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 cs  input  1  access request, sampled each clk edge.
REQ-007 we  input  1  1 = write, 0 = read; valid only with cs=1.
REQ-008 addr  input  ADDR_W  word address.
REQ-009 din  input  DATA_W  write data.
REQ-010 be  input  DATA_W/8  byte enables; bit i gates din[8i+7:8i].
REQ-011 clr  input  1  start a sequential clear of the whole array.
REQ-012 dout  output  DATA_W  registered read data.
REQ-013 rvalid  output  1  one-cycle pulse: dout updated this cycle.
REQ-014 err  output  1  one-cycle pulse: previous cycle's request rejected.
REQ-015 busy  output  1  clear sweep in progress.

Function
REQ-016 Storage SHALL be DEPTH x DATA_W flip-flops, no inferred RAM macro.
REQ-017 FSM SHALL have two states, IDLE and CLEAR.
REQ-018 IDLE, cs=1, we=1, clr=0, addr<DEPTH: at the edge, bytes with be[i]=1 SHALL take din; bytes with be[i]=0 keep their value; no rvalid.
REQ-019 IDLE, cs=1, we=0, clr=0, addr<DEPTH at edge N: dout SHALL equal mem[addr] as held before edge N, with rvalid=1 during cycle N+1 (latency 1).
REQ-020 Write with addr>=DEPTH: no storage change; err=1 in the next cycle.
REQ-021 Read with addr>=DEPTH: dout=0, rvalid=1 and err=1 in the next cycle.
REQ-022 When no read completes, dout SHALL hold its last value and rvalid SHALL be 0.
REQ-023 IDLE, clr=1: go to CLEAR; sweep index SHALL start at 0; busy=1 from the next cycle.
REQ-024 clr=1 together with cs=1 in IDLE: clr wins; the access is dropped with err=1 next cycle.
REQ-025 CLEAR: one word per cycle SHALL be zeroed, index 0..DEPTH-1; the word at index k is zeroed at edge N+1+k after clr at edge N.
REQ-026 After word DEPTH-1 is zeroed, the FSM SHALL return to IDLE; busy=0 from cycle N+1+DEPTH; sweep totals DEPTH cycles.
REQ-027 cs=1 during CLEAR: access ignored, no write, no rvalid, err=1 next cycle.
REQ-028 clr=1 during CLEAR: ignored; sweep continues unchanged with no err.
REQ-029 The sweep index SHALL be ceil(log2(DEPTH)) bits wide and SHALL never reach DEPTH.
REQ-030 Idle outputs: rvalid=0, err=0; busy=0 in IDLE.

Reset
REQ-031 rst=0 at an edge SHALL zero all DEPTH words in that single edge.
REQ-032 Reset SHALL set FSM=IDLE, sweep index=0, dout=0, rvalid=0, err=0, busy=0.
REQ-033 Reset SHALL override every simultaneous cs/we/clr request, including mid-sweep.
REQ-034 First access is accepted at the first edge with rst=1.

Verification
REQ-035 Reset, write 0xA5C3 to addr 5 with be=11, read addr 5 -> dout=0xA5C3, rvalid=1 exactly one cycle after the read edge.
REQ-036 mem[2]=0x1234, write 0xFFFF to addr 2 with be=01 -> read returns 0x12FF; with be=00 -> unchanged.
REQ-037 Write 0xBEEF to addr 8 (DEPTH=8) -> err=1 next cycle, all words unchanged; read addr 9 -> dout=0, rvalid=1, err=1.
REQ-038 Fill all words, pulse clr, issue read addr 3 during sweep -> busy high for exactly 8 cycles, read gives err=1 with no rvalid; afterwards all words read 0.
REQ-039 Reset asserted at sweep cycle 3 -> next cycle busy=0, FSM=IDLE, all words 0, write/read of 0x5A5A at addr 7 works at once.
REQ-040 Parameter run DATA_W=32, DEPTH=16 -> byte-enable and out-of-range checks repeated with be width 4 and boundary addr 15/16.

Source files
------------

// File: rtl/dffmem_array.sv
// dffmem_array: flip-flop word array with byte-enabled writes, registered
// reads, out-of-range error pulses and a one-word-per-cycle clear sweep.
module dffmem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cs,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   din,
    input  logic [DATA_W/8-1:0] be,
    input  logic                clr,
    output logic [DATA_W-1:0]   dout,
    output logic                rvalid,
    output logic                err,
    output logic                busy
);

    localparam int NBYTES = DATA_W / 8;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [IDX_W-1:0]   sweep_idx;
    logic [IDX_W-1:0]   sweep_idx_nx;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic               in_range;
    logic [IDX_W-1:0]   word_idx;
    logic               wr_go;
    logic               rd_go;
    logic               rd_oob;
    logic               clr_go;
    logic               err_nx;

    // One extra bit on the left so DEPTH itself is representable for the compare
    assign in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
    assign word_idx = addr[IDX_W-1:0];
    assign busy     = (state == CLEAR);

    // Next-state, sweep index and access decode
    always_comb begin
        state_nx     = state;
        sweep_idx_nx = sweep_idx;
        wr_go        = 1'b0;
        rd_go        = 1'b0;
        rd_oob       = 1'b0;
        clr_go       = 1'b0;
        err_nx       = 1'b0;
        case (state)
            IDLE: begin
                if (clr) begin
                    state_nx     = CLEAR;
                    sweep_idx_nx = '0;
                    err_nx       = cs;
                end else if (cs) begin
                    if (!in_range) begin
                        err_nx = 1'b1;
                        rd_oob = !we;
                    end else if (we) begin
                        wr_go = 1'b1;
                    end else begin
                        rd_go = 1'b1;
                    end
                end
            end
            CLEAR: begin
                clr_go = 1'b1;
                err_nx = cs;
                if (sweep_idx == LAST_IDX) begin
                    state_nx     = IDLE;
                    sweep_idx_nx = '0;
                end else begin
                    sweep_idx_nx = sweep_idx + IDX_W'(1);
                end
            end
            default: begin
                state_nx     = IDLE;
                sweep_idx_nx = '0;
            end
        endcase
    end

    // FSM state and sweep index registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            sweep_idx <= '0;
        end else begin
            state     <= state_nx;
            sweep_idx <= sweep_idx_nx;
        end
    end

    // Storage: reset zeroes every word at once, sweep zeroes one word per cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned w = 0; w < DEPTH; w++) begin
                mem[w] <= '0;
            end
        end else begin
            if (clr_go) begin
                mem[sweep_idx] <= '0;
            end
            if (wr_go) begin
                for (int unsigned b = 0; b < NBYTES; b++) begin
                    if (be[b]) begin
                        mem[word_idx][8*b +: 8] <= din[8*b +: 8];
                    end
                end
            end
        end
    end

    // Registered read data and response pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            dout   <= '0;
            rvalid <= 1'b0;
            err    <= 1'b0;
        end else begin
            rvalid <= rd_go | rd_oob;
            err    <= err_nx;
            if (rd_go) begin
                dout <= mem[word_idx];
            end else if (rd_oob) begin
                dout <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dffmem_array.sv
// Scoreboard bench for dffmem_array: two instances (16x8 and 32x16) driven
// from directed and random stimulus against an array/counter reference model.
module tb_dffmem_array;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v  [2];
    logic        cs_v   [2];
    logic        we_v   [2];
    logic        clr_v  [2];
    logic [11:0] addr_v [2];
    logic [31:0] din_v  [2];
    logic [3:0]  be_v   [2];

    logic [15:0] dout_a;
    logic        rvalid_a, err_a, busy_a;
    logic [31:0] dout_b;
    logic        rvalid_b, err_b, busy_b;

    dffmem_array #(.DATA_W(16), .DEPTH(8), .ADDR_W(12)) u_a (
        .clk(clk), .rst(rst_v[0]), .cs(cs_v[0]), .we(we_v[0]),
        .addr(addr_v[0]), .din(din_v[0][15:0]), .be(be_v[0][1:0]),
        .clr(clr_v[0]), .dout(dout_a), .rvalid(rvalid_a), .err(err_a),
        .busy(busy_a)
    );

    dffmem_array #(.DATA_W(32), .DEPTH(16), .ADDR_W(12)) u_b (
        .clk(clk), .rst(rst_v[1]), .cs(cs_v[1]), .we(we_v[1]),
        .addr(addr_v[1]), .din(din_v[1]), .be(be_v[1]),
        .clr(clr_v[1]), .dout(dout_b), .rvalid(rvalid_b), .err(err_b),
        .busy(busy_b)
    );

    typedef struct {
        int          inst;
        int unsigned st;
        logic        rv;
        logic        er;
        logic [31:0] d;
    } exp_t;

    exp_t        sbq [$];
    logic [31:0] mm  [2][16];
    int          left   [2];
    int          pos    [2];
    logic [31:0] cur_d  [2];
    int unsigned rst_st [2];
    int unsigned ecnt = 0;
    bit          mon_en = 1'b0;
    int          total = 0;
    int          bad = 0;

    always @(posedge clk) ecnt <= ecnt + 1;

    function automatic int dp_of(input int i);
        return (i == 0) ? 8 : 16;
    endfunction

    task automatic chk(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL inst%0d %s: got %h want %h (edge %0d)", i, nm, act, exp, ecnt);
        end
    endtask

    function automatic int find_idx(input int i);
        for (int j = 0; j < sbq.size(); j++)
            if (sbq[j].inst == i) return j;
        return -1;
    endfunction

    task automatic push(input int i, input int unsigned st, input logic rv, input logic er, input logic [31:0] d);
        exp_t e;
        e.inst = i; e.st = st; e.rv = rv; e.er = er; e.d = d;
        sbq.push_back(e);
    endtask

    // Reference model applied for one clock edge
    task automatic model_edge(input int i, input int unsigned st, input logic r, input logic c,
                              input logic w, input logic cl, input logic [11:0] a,
                              input logic [31:0] d, input logic [3:0] b);
        int dp = dp_of(i);
        int nb = (i == 0) ? 2 : 4;
        if (!r) begin
            for (int k = 0; k < 16; k++) mm[i][k] = '0;
            left[i] = 0; pos[i] = 0; rst_st[i] = st;
        end else if (left[i] > 0) begin
            if (c) push(i, st, 1'b0, 1'b1, '0);
            mm[i][pos[i]] = '0;
            pos[i]++; left[i]--;
        end else if (cl) begin
            if (c) push(i, st, 1'b0, 1'b1, '0);
            left[i] = dp; pos[i] = 0;
        end else if (c) begin
            if (int'(a) >= dp) begin
                if (w) push(i, st, 1'b0, 1'b1, '0);
                else   push(i, st, 1'b1, 1'b1, '0);
            end else if (w) begin
                for (int k = 0; k < nb; k++)
                    if (b[k]) mm[i][a][8*k +: 8] = d[8*k +: 8];
            end else begin
                push(i, st, 1'b1, 1'b0, mm[i][a]);
            end
        end
    endtask

    task automatic drive(input int i, input logic r, input logic c, input logic w, input logic cl,
                         input logic [11:0] a, input logic [31:0] d, input logic [3:0] b);
        int unsigned st;
        st = ecnt + 1;
        rst_v[i] = r; cs_v[i] = c; we_v[i] = w; clr_v[i] = cl;
        addr_v[i] = a; din_v[i] = d; be_v[i] = b;
        @(posedge clk);
        model_edge(i, st, r, c, w, cl, a, d, b);
        #1;
    endtask

    task automatic wr(input int i, input int a, input logic [31:0] d, input logic [3:0] b);
        drive(i, 1'b1, 1'b1, 1'b1, 1'b0, 12'(a), d, b);
    endtask

    task automatic rd(input int i, input int a);
        drive(i, 1'b1, 1'b1, 1'b0, 1'b0, 12'(a), $urandom, 4'($urandom));
    endtask

    task automatic idle(input int i, input int n);
        for (int k = 0; k < n; k++) drive(i, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic read_all(input int i);
        for (int k = 0; k < dp_of(i); k++) rd(i, k);
    endtask

    task automatic fill(input int i);
        for (int k = 0; k < dp_of(i); k++) wr(i, k, $urandom | 32'h0101_0101, 4'hF);
    endtask

    // Monitor: pop expected responses as the DUT presents them
    task automatic check_inst(input int i);
        logic        o_rv, o_er, o_bz;
        logic [31:0] o_d;
        int          k;
        o_rv = (i == 0) ? rvalid_a : rvalid_b;
        o_er = (i == 0) ? err_a    : err_b;
        o_bz = (i == 0) ? busy_a   : busy_b;
        o_d  = (i == 0) ? {16'h0, dout_a} : dout_b;
        if (ecnt == rst_st[i]) cur_d[i] = '0;
        k = find_idx(i);
        while (k >= 0 && sbq[k].st < ecnt) begin
            total++; bad++;
            $display("FAIL inst%0d missing_resp: got none want stamp %0d (edge %0d)", i, sbq[k].st, ecnt);
            sbq.delete(k);
            k = find_idx(i);
        end
        if (o_rv || o_er) begin
            if (k < 0 || sbq[k].st != ecnt) begin
                total++; bad++;
                $display("FAIL inst%0d spurious_resp: got rvalid=%b err=%b want none (edge %0d)", i, o_rv, o_er, ecnt);
            end else begin
                chk(i, "rvalid", 32'(o_rv), 32'(sbq[k].rv));
                chk(i, "err", 32'(o_er), 32'(sbq[k].er));
                if (sbq[k].rv) begin
                    chk(i, "dout_read", o_d, sbq[k].d);
                    cur_d[i] = sbq[k].d;
                end
                sbq.delete(k);
            end
        end else if (k >= 0 && sbq[k].st == ecnt) begin
            total++; bad++;
            $display("FAIL inst%0d no_resp: got rvalid=0 err=0 want rvalid=%b err=%b (edge %0d)", i, sbq[k].rv, sbq[k].er, ecnt);
            sbq.delete(k);
        end
        chk(i, "dout_hold", o_d, cur_d[i]);
        chk(i, "busy", 32'(o_bz), 32'(left[i] > 0));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) check_inst(i);
        end
    end

    task automatic run_inst(input int i);
        int          dp = dp_of(i);
        logic [31:0] ones = (i == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        logic [3:0]  all_be = (i == 0) ? 4'h3 : 4'hF;
        // reset contents, basic write/read
        read_all(i);
        wr(i, 5, 32'hA5C3, all_be);
        rd(i, 5);
        idle(i, 2);
        // byte enables
        wr(i, 2, 32'h1234, all_be);
        wr(i, 2, ones, 4'b0001);
        rd(i, 2);
        wr(i, 2, ones, 4'b0000);
        rd(i, 2);
        wr(i, 2, 32'h8765_4321, 4'b0110);
        rd(i, 2);
        // out-of-range boundary
        wr(i, dp, 32'hBEEF, all_be);
        rd(i, dp + 1);
        rd(i, dp);
        rd(i, dp - 1);
        wr(i, dp - 1, 32'hC0DE_F00D, all_be);
        rd(i, dp - 1);
        read_all(i);
        // clr with simultaneous access
        drive(i, 1'b1, 1'b1, 1'b0, 1'b1, 12'd3, '0, '0);
        idle(i, dp + 1);
        read_all(i);
        // sweep with access and repeated clr in the middle
        fill(i);
        drive(i, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0, '0);
        idle(i, 2);
        rd(i, 3);
        drive(i, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0, '0);
        wr(i, 1, 32'h5555_5555, all_be);
        idle(i, dp);
        read_all(i);
        // reset mid-sweep with a simultaneous request
        fill(i);
        drive(i, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0, '0);
        idle(i, 3);
        drive(i, 1'b0, 1'b1, 1'b1, 1'b1, 12'd7, 32'h1111_1111, 4'hF);
        wr(i, 7, 32'h5A5A, all_be);
        rd(i, 7);
        read_all(i);
        // random traffic
        for (int n = 0; n < 300; n++) begin
            drive(i, ($urandom_range(0, 79) != 0), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, ($urandom_range(0, 24) == 0),
                  12'($urandom_range(0, dp + 2)), $urandom, 4'($urandom));
        end
        idle(i, dp + 1);
        read_all(i);
        idle(i, 2);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_v[i] = 1'b0; cs_v[i] = 1'b0; we_v[i] = 1'b0; clr_v[i] = 1'b0;
            addr_v[i] = '0; din_v[i] = '0; be_v[i] = '0;
            left[i] = 0; pos[i] = 0; cur_d[i] = '0; rst_st[i] = 0;
            for (int k = 0; k < 16; k++) mm[i][k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_v[0] = 1'b1;
        rst_v[1] = 1'b1;
        mon_en = 1'b1;
        run_inst(0);
        run_inst(1);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
